// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller's change path:
// payout FSM states, coin selection and coin values in 25-cent units.
package vend_pkg;

    // Payout sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Which ejector the current pulse drives
    typedef enum logic {
        COIN_H50 = 1'b0,
        COIN_F25 = 1'b1
    } coin_t;

    // Coin values expressed in 25-cent units
    localparam int H50_UNITS = 2;
    localparam int F25_UNITS = 1;

    // Width of the shared pulse/gap timer
    localparam int TIMER_W = 8;

endpackage

// File: rtl/change_pulse_timer.sv
// Loadable down-counter used to time ejector pulses and inter-pulse gaps.
// A load always wins over counting; the count holds at zero, and tc_o flags
// that the current cycle is the last one of the loaded interval.
module change_pulse_timer
    import vend_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               tc_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: reload, decrement while enabled, or hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout executor: accepts an amount in 25-cent units and pays it out
// greedily as timed ejector pulses (50c coins first, then one 25c if odd),
// separated by gaps that Hold can stretch. All outputs are registered.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int AMT_W        = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ChangeValid,
    input  logic [AMT_W-1:0] ChangeAmt,
    input  logic             Hold,
    output logic             CoinH50,
    output logic             CoinF25,
    output logic             Busy,
    output logic             Done,
    output logic [AMT_W-1:0] Remaining
);

    // The timer flags terminal count on its zero cycle, so an interval of
    // N cycles is loaded as N-1.
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    // Greedy choice: a 50c coin whenever at least two units are still owed,
    // which also guarantees the decrement never exceeds what is owed.
    function automatic coin_t pick_coin(input logic [AMT_W-1:0] amt);
        return (amt >= AMT_W'(H50_UNITS)) ? COIN_H50 : COIN_F25;
    endfunction

    function automatic logic [AMT_W-1:0] coin_units(input coin_t coin);
        return (coin == COIN_H50) ? AMT_W'(H50_UNITS) : AMT_W'(F25_UNITS);
    endfunction

    state_t             state_q;
    coin_t              coin_q;
    logic               h50_q;
    logic               f25_q;
    logic               busy_q;
    logic               done_q;
    logic [AMT_W-1:0]   rem_q;

    logic               tmr_load_d;
    logic [TIMER_W-1:0] tmr_val_d;
    logic               tmr_en_d;
    logic               tmr_tc;

    coin_t              next_coin;
    logic               gap_end;

    // Coin for the pulse about to start: from the request in IDLE, otherwise
    // from the amount still owed.
    assign next_coin = pick_coin((state_q == IDLE) ? ChangeAmt : rem_q);
    assign gap_end   = tmr_tc && !Hold;

    // Timer control: reload on every PULSE/GAP entry, clear on entry to the
    // other states; Hold only freezes the gap, never a pulse.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = '0;
        tmr_en_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (ChangeValid) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = (ChangeAmt != '0) ? PULSE_LOAD : '0;
                end
            end
            PULSE: begin
                if (tmr_tc) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = GAP_LOAD;
                end
            end
            GAP: begin
                tmr_en_d = !Hold;
                if (gap_end) begin
                    tmr_load_d = 1'b1;
                    tmr_val_d  = (rem_q != '0) ? PULSE_LOAD : '0;
                end
            end
            DONE: begin
                tmr_load_d = 1'b1;
                tmr_val_d  = '0;
            end
            default: begin
                tmr_load_d = 1'b1;
                tmr_val_d  = '0;
            end
        endcase
    end

    change_pulse_timer u_timer (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .en_i       (tmr_en_d),
        .tc_o       (tmr_tc)
    );

    // Payout sequencer with registered coin, progress and status outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            coin_q  <= COIN_F25;
            h50_q   <= 1'b0;
            f25_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (ChangeValid) begin
                        rem_q  <= ChangeAmt;
                        busy_q <= 1'b1;
                        if (ChangeAmt == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PULSE;
                            coin_q  <= next_coin;
                            h50_q   <= (next_coin == COIN_H50);
                            f25_q   <= (next_coin == COIN_F25);
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                PULSE: begin
                    if (tmr_tc) begin
                        rem_q   <= rem_q - coin_units(coin_q);
                        h50_q   <= 1'b0;
                        f25_q   <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (rem_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PULSE;
                            coin_q  <= next_coin;
                            h50_q   <= (next_coin == COIN_H50);
                            f25_q   <= (next_coin == COIN_F25);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    h50_q   <= 1'b0;
                    f25_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rem_q   <= '0;
                end
            endcase
        end
    end

    assign CoinH50   = h50_q;
    assign CoinF25   = f25_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Remaining = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized payouts,
// each compared cycle by cycle against a timeline built from the payout rules.
module tb_change_dispenser;

    localparam int P    = 4;
    localparam int G    = 2;
    localparam int AW   = 4;
    localparam int MAXC = 512;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          ChangeValid;
    logic [AW-1:0] ChangeAmt;
    logic          Hold;
    logic          CoinH50;
    logic          CoinF25;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] Remaining;

    int n_tests = 0;
    int n_fail  = 0;

    int e_h50  [MAXC];
    int e_f25  [MAXC];
    int e_busy [MAXC];
    int e_done [MAXC];
    int e_rem  [MAXC];
    bit hv     [MAXC];

    change_dispenser #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .AMT_W        (AW)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .ChangeValid (ChangeValid),
        .ChangeAmt   (ChangeAmt),
        .Hold        (Hold),
        .CoinH50     (CoinH50),
        .CoinF25     (CoinF25),
        .Busy        (Busy),
        .Done        (Done),
        .Remaining   (Remaining)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    task automatic check_outputs(input string pfx, input int h50, input int f25,
                                 input int busy, input int done, input int rem);
        check({pfx, " CoinH50"},   32'(CoinH50),   32'(h50));
        check({pfx, " CoinF25"},   32'(CoinF25),   32'(f25));
        check({pfx, " Busy"},      32'(Busy),      32'(busy));
        check({pfx, " Done"},      32'(Done),      32'(done));
        check({pfx, " Remaining"}, 32'(Remaining), 32'(rem));
        check({pfx, " overlap"},   32'(CoinH50 & CoinF25), 32'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            ChangeValid = 1'b0;
            Hold        = 1'($urandom_range(0, 1));
            check_outputs($sformatf("idle%0d", i), 0, 0, 0, 0, 0);
        end
        Hold = 1'b0;
    endtask

    // hold_mode: 0 none, 1 random, 2 cycles 5..8
    // spam_mode: 0 none, 1 random requests while busy, 2 amt 5 at cycles 2 and 7
    // rst_at:    0 none, -1 random cycle within the payout, >0 that cycle
    task automatic run_txn(input int amt, input int hold_mode, input int spam_mode, input int rst_at_in);
        int c;
        int rem;
        int coin;
        int g;
        int last;
        int stop;
        int rst_at;
        string pfx;

        for (int i = 0; i < MAXC; i++) begin
            e_h50[i] = 0; e_f25[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_rem[i] = 0;
            case (hold_mode)
                1:       hv[i] = ($urandom_range(0, 2) == 0);
                2:       hv[i] = (i >= 5 && i <= 8);
                default: hv[i] = 1'b0;
            endcase
        end

        // Timeline from the payout rules: greedy coins, fixed pulses,
        // gaps that need G cycles without Hold, then a single Done cycle.
        c   = 1;
        rem = amt;
        while (rem > 0 && c < MAXC - 2) begin
            coin = (rem >= 2) ? 2 : 1;
            for (int k = 0; k < P; k++) begin
                e_h50[c] = (coin == 2); e_f25[c] = (coin == 1);
                e_busy[c] = 1; e_rem[c] = rem;
                c++;
            end
            rem -= coin;
            g = 0;
            while (g < G && c < MAXC - 2) begin
                e_busy[c] = 1; e_rem[c] = rem;
                if (!hv[c]) g++;
                c++;
            end
        end
        last = c;
        e_done[last] = 1; e_busy[last] = 1; e_rem[last] = 0;

        rst_at = (rst_at_in < 0) ? int'($urandom_range(1, last)) : rst_at_in;
        stop   = (rst_at > 0) ? rst_at + 1 : last + 1;

        @(negedge CLK);
        ChangeValid = 1'b1;
        ChangeAmt   = AW'(amt);
        Hold        = 1'b0;
        Reset       = 1'b0;

        for (c = 1; c <= stop; c++) begin
            @(negedge CLK);
            Reset = (rst_at > 0 && c == rst_at);
            Hold  = hv[c];
            if (spam_mode == 1 && c <= last) begin
                ChangeValid = 1'($urandom_range(0, 1));
                ChangeAmt   = AW'($urandom_range(0, 15));
            end else if (spam_mode == 2 && (c == 2 || c == 7)) begin
                ChangeValid = 1'b1;
                ChangeAmt   = AW'(5);
            end else begin
                ChangeValid = 1'b0;
            end
            if (c == stop) ChangeValid = 1'b0;
            pfx = $sformatf("amt%0d c%0d", amt, c);
            if (rst_at > 0 && c == rst_at + 1)
                check_outputs({pfx, " after-reset"}, 0, 0, 0, 0, 0);
            else
                check_outputs(pfx, e_h50[c], e_f25[c], e_busy[c], e_done[c], e_rem[c]);
        end
        Hold  = 1'b0;
        Reset = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        ChangeValid = 1'b0;
        ChangeAmt   = '0;
        Hold        = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outputs("reset", 0, 0, 0, 0, 0);
        Reset = 1'b0;
        idle_cycles(2);

        // Directed scenarios
        run_txn(3, 0, 0, 0);
        idle_cycles(1);
        run_txn(0, 0, 0, 0);
        idle_cycles(1);
        run_txn(15, 0, 0, 0);
        run_txn(2, 2, 0, 0);
        idle_cycles(1);
        run_txn(4, 0, 0, 3);
        idle_cycles(1);
        run_txn(1, 0, 0, 0);
        run_txn(2, 0, 2, 0);
        idle_cycles(1);
        run_txn(1, 1, 1, 0);

        // Randomized payouts with Hold noise, ignored requests and resets
        for (int t = 0; t < 30; t++) begin
            run_txn(int'($urandom_range(0, 15)), 1, 1,
                    ($urandom_range(0, 5) == 0) ? -1 : 0);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Receiver/executor end of the vending controller's change interface: accepts a change amount from the vending FSM and pays it out as timed coin-ejector pulses.
- Pays out greedily: 50-cent coins first (H50), then 25-cent coins (F25).
- Sits between the vending FSM output logic and the coin-ejector solenoids, and reports progress back to the FSM and the display path.

Parameters:
- PULSE_CYCLES, 4: clock cycles each ejector pulse is held high (legal range 1..255).
- GAP_CYCLES, 2: minimum low cycles between consecutive pulses (legal range 1..255).
- AMT_W, 4: width of the change amount, in 25-cent units.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ChangeValid  in  1  request strobe; sampled only in IDLE.
- ChangeAmt  in  AMT_W  change owed, in 25-cent units (0..15); sampled with ChangeValid.
- Hold  in  1  pause request; freezes the GAP timer.
- CoinH50  out  1  50-cent ejector pulse.
- CoinF25  out  1  25-cent ejector pulse.
- Busy  out  1  high from the request-accept edge through the DONE cycle.
- Done  out  1  one-cycle completion pulse.
- Remaining  out  AMT_W  amount still to pay, in 25-cent units.

Behaviour:
- All outputs are registered. Reset values: CoinH50=0, CoinF25=0, Busy=0, Done=0, Remaining=0, state=IDLE, timer=0.
- Reset mid-payout aborts at the next edge: all outputs 0, partial coins are not recounted, and state returns to IDLE.
- States: IDLE, PULSE, GAP, DONE.
- IDLE:
  - On an edge with ChangeValid=1: Remaining<=ChangeAmt and Busy<=1.
  - If ChangeAmt==0, go to DONE. Otherwise go to PULSE, choosing the coin at this edge: H50 if ChangeAmt>=2, else F25.
- PULSE:
  - The selected coin output is high for exactly PULSE_CYCLES cycles; the other coin output stays 0.
  - Hold is ignored; a pulse always completes.
  - On the final PULSE cycle's edge: Remaining decrements by 2 (H50) or 1 (F25), the coin output goes low, and state goes to GAP.
- GAP:
  - Both coin outputs are 0 for GAP_CYCLES cycles.
  - While Hold=1 the timer does not advance, so GAP is extended by the number of Hold cycles.
  - At gap end: if Remaining==0 go to DONE. Otherwise go to PULSE with a fresh coin choice (H50 if Remaining>=2, else F25).
- DONE:
  - Lasts exactly one cycle, with Done=1 and Busy=1.
  - Next state is IDLE with Busy=0.
- Latency: the first coin goes high in the cycle after the accept edge.
  - Total cycles from accept to DONE = N_coins*(PULSE_CYCLES+GAP_CYCLES) + 1.
  - N_coins = floor(Amt/2) + (Amt mod 2).
- ChangeValid outside IDLE, including during DONE, is ignored and not queued.
- CoinH50 and CoinF25 are never high in the same cycle.
- Remaining never underflows, because the coin choice guarantees the decrement is <= Remaining.
- Timer width is 8 bits; it resets to 0 on every state entry.

Decomposition:
- Shared package vend_pkg holds:
  - the state enum {IDLE, PULSE, GAP, DONE};
  - coin-value constants H50_UNITS=2 and F25_UNITS=1;
  - the coin-select enum {COIN_H50, COIN_F25}.
- One sub-module, change_pulse_timer: a loadable 8-bit down-counter with enable (driven low by Hold) and a terminal-count flag. It is instantiated once and reloaded on each PULSE/GAP entry.

Test Plan (all with PULSE_CYCLES=4, GAP_CYCLES=2; cycle 0 = ChangeValid high):
- ChangeAmt=3 -> CoinH50 high cycles 1-4, Remaining=1 from cycle 5, gap 5-6, CoinF25 high cycles 7-10, Remaining=0 from cycle 11, gap 11-12, Done=1 in cycle 13, Busy=1 in cycles 1-13 and 0 in cycle 14.
- ChangeAmt=0 -> Done=1 and Busy=1 in cycle 1 only, no coin pulses, Remaining=0 throughout.
- ChangeAmt=15 -> seven H50 pulses then one F25 pulse, coins never overlap, Done=1 in cycle 49, Remaining sequence 15,13,...,1,0.
- ChangeAmt=2 with Hold=1 during cycles 5-8 -> gap extends so that Done=1 in cycle 11 instead of 7; a Hold asserted during PULSE does not shorten or extend the pulse.
- ChangeAmt=4, Reset=1 in cycle 3 -> in cycle 4 CoinH50=0, Busy=0, Remaining=0, state IDLE; a new request of 1 in cycle 6 yields CoinF25 high in cycles 7-10.
- ChangeAmt=2, then ChangeValid with ChangeAmt=5 in cycles 2 and 7 -> both ignored; only one H50 pulse occurs and Done=1 in cycle 7.
